// File: rtl/can_pkg.sv
// Shared types, field widths and helpers for the CAN base-frame receive path.
package can_pkg;

  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int CRC_W     = 15;
  localparam int MAX_BYTES = 8;

  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 15'h4599;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK,
    ST_ACK_DEL,
    ST_EOF,
    ST_ERROR
  } can_state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_FORM  = 3'd2;
  localparam logic [2:0] ERR_CRC   = 3'd3;

  localparam int RV_OK_BIT  = 0;
  localparam int RV_ERR_LSB = 1;
  localparam int RV_CNT_LSB = 4;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic b,
                                                input logic [CRC_W-1:0] poly);
    logic nxt;
    nxt = b ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (nxt ? poly : '0);
  endfunction

  function automatic logic [31:0] pack_status(input logic ok,
                                              input logic [2:0] code,
                                              input logic [3:0] cnt);
    logic [31:0] s;
    s = '0;
    s[RV_OK_BIT]       = ok;
    s[RV_ERR_LSB +: 3] = code;
    s[RV_CNT_LSB +: 4] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/can_destuff.sv
// Removes stuff bits from the bus stream; a SOF strobe re-seeds the run tracker.
module can_destuff
  import can_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic enable,
  input  logic sof,
  output logic data_valid,
  output logic data_bit,
  output logic stuff_err
);

  logic [2:0] run_d, run_q;
  logic       last_d, last_q;

  always_comb begin
    run_d      = run_q;
    last_d     = last_q;
    data_valid = 1'b0;
    data_bit   = bit_in;
    stuff_err  = 1'b0;
    if (bit_valid) begin
      if (sof) begin
        run_d  = 3'd1;
        last_d = 1'b0;
      end else if (enable) begin
        // A full run of five means this bit is a stuff bit, never data.
        if (run_q == 3'd5) begin
          if (bit_in == last_q) begin
            stuff_err = 1'b1;
          end else begin
            run_d  = 3'd1;
            last_d = bit_in;
          end
        end else begin
          data_valid = 1'b1;
          run_d      = (bit_in == last_q) ? run_q + 3'd1 : 3'd1;
          last_d     = bit_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 3'd0;
      last_q <= 1'b1;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/can_rx_frame.sv
// CAN 2.0A base-frame receiver: field capture, CRC-15 check, ACK drive and status report.
module can_rx_frame
  import can_pkg::*;
#(
  parameter int               EOF_LEN  = 7,
  parameter int               IDLE_LEN = 11,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        ack_out,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        finish,
  output logic [31:0] return_val
);

  can_state_e        state_d, state_q;
  logic [6:0]        cnt_d, cnt_q;
  logic [ID_W-1:0]   id_d, id_q;
  logic              rtr_d, rtr_q;
  logic [DLC_W-1:0]  dlc_d, dlc_q;
  logic [63:0]       data_d, data_q;
  logic [CRC_W-1:0]  crc_d, crc_q;
  logic [CRC_W-1:0]  crc_rx_d, crc_rx_q;
  logic              crc_ok_d, crc_ok_q;
  logic [3:0]        nbytes_d, nbytes_q;
  logic [3:0]        byte_cnt_d, byte_cnt_q;
  logic              ack_d, ack_q;
  logic              finish_d, finish_q;
  logic [31:0]       ret_d, ret_q;
  logic [ID_W-1:0]   rx_id_d, rx_id_q;
  logic              rx_rtr_d, rx_rtr_q;
  logic [DLC_W-1:0]  rx_dlc_d, rx_dlc_q;
  logic [63:0]       rx_data_d, rx_data_q;

  logic              err_hit;
  logic [2:0]        err_code;
  logic              eof_done;

  logic              ds_valid, ds_bit, ds_err, ds_sof, ds_en;
  logic [DLC_W-1:0]  dlc_shift;
  logic [3:0]        nb_calc;
  logic [6:0]        data_last;
  logic [CRC_W-1:0]  crc_rx_next;

  assign ds_sof = (state_q == ST_IDLE) && !bit_in;
  assign ds_en  = (state_q == ST_ARB) || (state_q == ST_CTRL) ||
                  (state_q == ST_DATA) || (state_q == ST_CRC);

  can_destuff u_destuff (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .enable     (ds_en),
    .sof        (ds_sof),
    .data_valid (ds_valid),
    .data_bit   (ds_bit),
    .stuff_err  (ds_err)
  );

  assign dlc_shift   = {dlc_q[DLC_W-2:0], ds_bit};
  assign nb_calc     = rtr_q ? 4'd0 : ((dlc_shift > 4'd8) ? 4'd8 : dlc_shift);
  assign data_last   = {nbytes_q, 3'b000} - 7'd1;
  assign crc_rx_next = {crc_rx_q[CRC_W-2:0], ds_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rtr_d      = rtr_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    crc_d      = crc_q;
    crc_rx_d   = crc_rx_q;
    crc_ok_d   = crc_ok_q;
    nbytes_d   = nbytes_q;
    byte_cnt_d = byte_cnt_q;
    ack_d      = ack_q;
    finish_d   = 1'b0;
    ret_d      = ret_q;
    rx_id_d    = rx_id_q;
    rx_rtr_d   = rx_rtr_q;
    rx_dlc_d   = rx_dlc_q;
    rx_data_d  = rx_data_q;
    err_hit    = 1'b0;
    err_code   = ERR_NONE;
    eof_done   = 1'b0;

    if (ds_err) begin
      err_hit  = 1'b1;
      err_code = ERR_STUFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bit_valid && !bit_in) begin
            crc_d      = '0;
            data_d     = '0;
            id_d       = '0;
            rtr_d      = 1'b0;
            dlc_d      = '0;
            crc_rx_d   = '0;
            crc_ok_d   = 1'b0;
            nbytes_d   = '0;
            byte_cnt_d = '0;
            cnt_d      = '0;
            state_d    = ST_ARB;
          end
        end
        ST_ARB: begin
          if (ds_valid) begin
            crc_d = crc_step(crc_q, ds_bit, CRC_POLY);
            if (cnt_q < 7'd11) begin
              id_d  = {id_q[ID_W-2:0], ds_bit};
              cnt_d = cnt_q + 7'd1;
            end else begin
              rtr_d   = ds_bit;
              cnt_d   = '0;
              state_d = ST_CTRL;
            end
          end
        end
        ST_CTRL: begin
          if (ds_valid) begin
            crc_d = crc_step(crc_q, ds_bit, CRC_POLY);
            if (cnt_q == 7'd0 && ds_bit) begin
              err_hit  = 1'b1;
              err_code = ERR_FORM;
            end else if (cnt_q < 7'd2) begin
              cnt_d = cnt_q + 7'd1;
            end else begin
              dlc_d = dlc_shift;
              if (cnt_q == 7'd5) begin
                nbytes_d = nb_calc;
                cnt_d    = '0;
                state_d  = (nb_calc == 4'd0) ? ST_CRC : ST_DATA;
              end else begin
                cnt_d = cnt_q + 7'd1;
              end
            end
          end
        end
        ST_DATA: begin
          if (ds_valid) begin
            crc_d = crc_step(crc_q, ds_bit, CRC_POLY);
            // Payload fills from bit 63 downward so byte 0 lands in [63:56].
            data_d[~cnt_q[5:0]] = ds_bit;
            if (cnt_q[2:0] == 3'd7) byte_cnt_d = byte_cnt_q + 4'd1;
            if (cnt_q == data_last) begin
              cnt_d   = '0;
              state_d = ST_CRC;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        ST_CRC: begin
          if (ds_valid) begin
            crc_rx_d = crc_rx_next;
            if (cnt_q == 7'd14) begin
              crc_ok_d = (crc_rx_next == crc_q);
              cnt_d    = '0;
              state_d  = ST_CRC_DEL;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        ST_CRC_DEL: begin
          if (bit_valid) begin
            if (!bit_in) begin
              err_hit  = 1'b1;
              err_code = ERR_FORM;
            end else begin
              ack_d   = crc_ok_q;
              state_d = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (bit_valid) begin
            ack_d   = 1'b0;
            state_d = ST_ACK_DEL;
          end
        end
        ST_ACK_DEL: begin
          if (bit_valid) begin
            if (!bit_in) begin
              err_hit  = 1'b1;
              err_code = ERR_FORM;
            end else begin
              cnt_d   = '0;
              state_d = ST_EOF;
            end
          end
        end
        ST_EOF: begin
          if (bit_valid) begin
            if (!bit_in) begin
              err_hit  = 1'b1;
              err_code = ERR_FORM;
            end else if (cnt_q == 7'(EOF_LEN - 1)) begin
              eof_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        ST_ERROR: begin
          if (bit_valid) begin
            if (!bit_in) begin
              cnt_d = '0;
            end else if (cnt_q == 7'(IDLE_LEN - 1)) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (err_hit || eof_done) begin
      finish_d  = 1'b1;
      ack_d     = 1'b0;
      cnt_d     = '0;
      rx_id_d   = id_q;
      rx_rtr_d  = rtr_q;
      rx_dlc_d  = dlc_q;
      rx_data_d = data_q;
      if (err_hit) begin
        ret_d   = pack_status(1'b0, err_code, byte_cnt_q);
        state_d = ST_ERROR;
      end else begin
        ret_d   = pack_status(crc_ok_q, crc_ok_q ? ERR_NONE : ERR_CRC, byte_cnt_q);
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      crc_q      <= '0;
      crc_rx_q   <= '0;
      crc_ok_q   <= 1'b0;
      nbytes_q   <= '0;
      byte_cnt_q <= '0;
      ack_q      <= 1'b0;
      finish_q   <= 1'b0;
      ret_q      <= '0;
      rx_id_q    <= '0;
      rx_rtr_q   <= 1'b0;
      rx_dlc_q   <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rtr_q      <= rtr_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      crc_q      <= crc_d;
      crc_rx_q   <= crc_rx_d;
      crc_ok_q   <= crc_ok_d;
      nbytes_q   <= nbytes_d;
      byte_cnt_q <= byte_cnt_d;
      ack_q      <= ack_d;
      finish_q   <= finish_d;
      ret_q      <= ret_d;
      rx_id_q    <= rx_id_d;
      rx_rtr_q   <= rx_rtr_d;
      rx_dlc_q   <= rx_dlc_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign ack_out    = ack_q;
  assign finish     = finish_q;
  assign return_val = ret_q;
  assign rx_id      = rx_id_q;
  assign rx_rtr     = rx_rtr_q;
  assign rx_dlc     = rx_dlc_q;
  assign rx_data    = rx_data_q;

endmodule

// File: tb/tb_can_rx_frame.sv
// Bench for can_rx_frame: frames are built from field values, CRC'd and stuffed by a reference model.
module tb_can_rx_frame;

  localparam logic [14:0] POLY = 15'h4599;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_valid;
  logic        bit_in;
  logic        ack_out;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        finish;
  logic [31:0] return_val;

  can_rx_frame dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .ack_out    (ack_out),
    .rx_id      (rx_id),
    .rx_rtr     (rx_rtr),
    .rx_dlc     (rx_dlc),
    .rx_data    (rx_data),
    .finish     (finish),
    .return_val (return_val)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fin_cnt = 0;
  logic        prev_fin = 1'b0;
  logic        frame_q[$];
  logic [31:0] exp_q[$];
  logic [63:0] exp_data;
  int          ack_idx;
  int          ack_hits;
  logic        ack_at_slot;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Finish monitor: counts pulses and flags any back-to-back pulse.
  always @(negedge clk) begin
    if (finish === 1'b1) begin
      fin_cnt++;
      checks++;
      assert (prev_fin !== 1'b1) else begin
        errors++;
        $error("FAIL finish_back_to_back observed=1 expected=0");
      end
    end
    prev_fin = finish;
  end

  // Reference model: raw field bits, CRC over SOF..data, stuffing through the CRC field.
  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] payload, input int flip_bit);
    logic       raw[$];
    logic [14:0] c;
    logic       nxt;
    logic       last;
    int         nb;
    int         run;
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    exp_data = '0;
    for (int i = 0; i < nb * 8; i++) begin
      raw.push_back(payload[63-i]);
      exp_data[63-i] = payload[63-i];
    end
    c = '0;
    foreach (raw[k]) begin
      nxt = raw[k] ^ c[14];
      c = {c[13:0], 1'b0} ^ (nxt ? POLY : 15'h0);
    end
    if (flip_bit >= 0) c[flip_bit] = ~c[flip_bit];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    frame_q.delete();
    run = 0;
    last = 1'b1;
    for (int k = 0; k < raw.size(); k++) begin
      frame_q.push_back(raw[k]);
      if (raw[k] == last) run++;
      else begin
        run = 1;
        last = raw[k];
      end
      if (run == 5 && k < raw.size() - 1) begin
        frame_q.push_back(~last);
        last = ~last;
        run = 1;
      end
    end
    frame_q.push_back(1'b1);
    ack_idx = frame_q.size();
    frame_q.push_back(1'b1);
    frame_q.push_back(1'b1);
    repeat (7) frame_q.push_back(1'b1);
    exp_q.push_back({24'd0, 4'(nb), (flip_bit >= 0) ? 3'd3 : 3'd0, (flip_bit < 0)});
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input int nbits);
    int f0;
    f0 = fin_cnt;
    ack_hits = 0;
    ack_at_slot = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (ack_out === 1'b1) ack_hits++;
      if (i == ack_idx) ack_at_slot = ack_out;
      if (i == nbits - 1 && nbits == frame_q.size()) chk("no_early_finish", 64'(fin_cnt), 64'(f0));
      send_bit(frame_q[i]);
    end
  endtask

  task automatic run_frame(input string tag, input logic [10:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] payload, input int flip_bit);
    int          f0;
    logic [31:0] exp_ret;
    build_frame(id, rtr, dlc, payload, flip_bit);
    f0 = fin_cnt;
    send_frame(frame_q.size());
    repeat (2) @(negedge clk);
    exp_ret = exp_q.pop_front();
    chk({tag, "_finish_count"}, 64'(fin_cnt - f0), 64'd1);
    chk({tag, "_return_val"}, 64'(return_val), 64'(exp_ret));
    chk({tag, "_rx_id"}, 64'(rx_id), 64'(id));
    chk({tag, "_rx_rtr"}, 64'(rx_rtr), 64'(rtr));
    chk({tag, "_rx_dlc"}, 64'(rx_dlc), 64'(dlc));
    chk({tag, "_rx_data"}, rx_data, exp_data);
    chk({tag, "_ack_hits"}, 64'(ack_hits), (flip_bit < 0) ? 64'd1 : 64'd0);
    chk({tag, "_ack_at_slot"}, 64'(ack_at_slot), (flip_bit < 0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int f0;
    reset = 1'b1;
    bit_valid = 1'b0;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_finish", 64'(finish), 64'd0);
    chk("reset_return_val", 64'(return_val), 64'd0);
    chk("reset_ack", 64'(ack_out), 64'd0);
    chk("reset_rx_id", 64'(rx_id), 64'd0);
    chk("reset_rx_data", rx_data, 64'd0);

    run_frame("s1", 11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
    chk("s1_ret_const", 64'(return_val), 64'h11);
    chk("s1_byte0", 64'(rx_data[63:56]), 64'hA5);

    run_frame("s2", 11'h000, 1'b0, 4'd0, 64'd0, -1);
    chk("s2_ret_const", 64'(return_val), 64'h01);

    run_frame("s3", 11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 0);
    chk("s3_ret_const", 64'(return_val), 64'h16);

    // Six dominant bits: SOF plus five ID bits of zero trip the stuff rule.
    f0 = fin_cnt;
    repeat (6) send_bit(1'b0);
    repeat (2) @(negedge clk);
    chk("s4_finish_count", 64'(fin_cnt - f0), 64'd1);
    chk("s4_err_code", 64'(return_val[3:1]), 64'd1);
    chk("s4_return_val", 64'(return_val), 64'h02);
    f0 = fin_cnt;
    repeat (20) send_bit(1'b0);
    repeat (10) send_bit(1'b1);
    build_frame(11'h2AA, 1'b0, 4'd2, 64'h1234_0000_0000_0000, -1);
    void'(exp_q.pop_front());
    send_frame(frame_q.size());
    repeat (2) @(negedge clk);
    chk("s4_error_swallows_frame", 64'(fin_cnt - f0), 64'd0);
    repeat (11) send_bit(1'b1);
    run_frame("s4_rearm", 11'h2AA, 1'b0, 4'd2, 64'h1234_0000_0000_0000, -1);

    run_frame("s5", 11'h7F0, 1'b0, 4'd15, 64'h0102030405060708, -1);
    chk("s5_ret_const", 64'(return_val), 64'h81);

    build_frame(11'h555, 1'b0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D, -1);
    void'(exp_q.pop_front());
    f0 = fin_cnt;
    send_frame(30);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("s6_no_finish", 64'(fin_cnt - f0), 64'd0);
    chk("s6_return_val", 64'(return_val), 64'd0);
    chk("s6_rx_id", 64'(rx_id), 64'd0);
    chk("s6_rx_dlc", 64'(rx_dlc), 64'd0);
    chk("s6_rx_data", rx_data, 64'd0);
    chk("s6_ack", 64'(ack_out), 64'd0);
    run_frame("s6_after", 11'h555, 1'b0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D, -1);

    for (int n = 0; n < 16; n++) begin
      logic [10:0] rid;
      logic        rrtr;
      logic [3:0]  rdlc;
      logic [63:0] rpay;
      int          rflip;
      rid   = 11'($urandom_range(0, 2047));
      rrtr  = ($urandom_range(0, 3) == 0);
      rdlc  = 4'($urandom_range(0, 15));
      rpay  = {$urandom, $urandom};
      rflip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      run_frame("rnd", rid, rrtr, rdlc, rpay, rflip);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
